lcd_cmd_arbiter: RTL and testbench

//   Shares one character-LCD command port (lcd_enable / lcd_bus / busy) among NREQ requesters.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/lcd_cmd_arbiter.sv | 105 ++++++++++
 tb/tb_lcd_cmd_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command arbiter.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitHi,
        StWaitLo,
        StDone
    } lcd_arb_state_t;

    // Command word layout: {rs, rw, data[7:0]}
    localparam int unsigned CMD_W    = 10;
    localparam int unsigned RS_BIT   = 9;
    localparam int unsigned RW_BIT   = 8;
    localparam int unsigned DATA_MSB = 7;

    // Increment with explicit wrap so non-power-of-2 requester counts work.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, modulo NREQ.
module rr_arbiter #(
    parameter  int unsigned NREQ = 3,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_idx
);

    logic [IDW-1:0] idx;

    // Walk offsets from the farthest down to ptr so the nearest hit is assigned last and wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr) + i) % int'(NREQ));
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin sharing of one character-LCD command port; one command per grant,
// completing on the busy rise/fall handshake or on timeout.
module lcd_cmd_arbiter #(
    parameter  int unsigned NREQ  = 3,
    parameter  int unsigned CMD_W = 10,
    parameter  int unsigned TMO   = 4095,
    parameter  int unsigned TMO_W = 12,
    localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CMD_W-1:0] cmd,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic [IDW-1:0]        gnt_id,
    output logic                  lcd_enable,
    output logic [CMD_W-1:0]      lcd_bus,
    input  logic                  busy
);

    import lcd_pkg::*;

    lcd_arb_state_t   state;
    logic [IDW-1:0]   ptr;
    logic [TMO_W-1:0] cnt;
    logic             tmo_flag;
    logic             arb_valid;
    logic [IDW-1:0]   arb_idx;
    logic             tmo_hit;

    assign tmo_hit = (cnt == TMO_W'(TMO));

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            ptr        <= '0;
            cnt        <= '0;
            tmo_flag   <= 1'b0;
            ack        <= '0;
            err        <= 1'b0;
            gnt_id     <= '0;
            lcd_enable <= 1'b0;
            lcd_bus    <= '0;
        end else begin
            lcd_enable <= 1'b0;
            ack        <= '0;
            err        <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!busy && arb_valid) begin
                        gnt_id  <= arb_idx;
                        lcd_bus <= cmd[arb_idx*CMD_W +: CMD_W];
                        state   <= StIssue;
                    end
                end
                StIssue: begin
                    lcd_enable <= 1'b1;
                    cnt        <= '0;
                    state      <= StWaitHi;
                end
                StWaitHi: begin
                    // The strobe cycle itself is not counted: busy cannot react to it yet.
                    if (busy) begin
                        cnt   <= '0;
                        state <= StWaitLo;
                    end else if (tmo_hit) begin
                        tmo_flag <= 1'b1;
                        state    <= StDone;
                    end else if (!lcd_enable) begin
                        cnt <= cnt + TMO_W'(1);
                    end
                end
                StWaitLo: begin
                    if (!busy) begin
                        state <= StDone;
                    end else if (tmo_hit) begin
                        tmo_flag <= 1'b1;
                        state    <= StDone;
                    end else begin
                        cnt <= cnt + TMO_W'(1);
                    end
                end
                StDone: begin
                    ack[gnt_id] <= 1'b1;
                    err         <= tmo_flag;
                    tmo_flag    <= 1'b0;
                    ptr         <= IDW'(wrap_inc(32'(gnt_id), NREQ));
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter with a simple busy-handshake LCD model.
module tb_lcd_cmd_arbiter;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned CMD_W = 10;
    localparam int unsigned TMO   = 4095;
    localparam int unsigned TMO_W = 12;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*CMD_W-1:0] cmd;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [IDW-1:0]        gnt_id;
    logic                  lcd_enable;
    logic [CMD_W-1:0]      lcd_bus;
    logic                  busy;

    int n_vec = 0;
    int n_bad = 0;

    logic [CMD_W-1:0] cmd_tab [NREQ];

    lcd_cmd_arbiter #(
        .NREQ  (NREQ),
        .CMD_W (CMD_W),
        .TMO   (TMO),
        .TMO_W (TMO_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .cmd        (cmd),
        .ack        (ack),
        .err        (err),
        .gnt_id     (gnt_id),
        .lcd_enable (lcd_enable),
        .lcd_bus    (lcd_bus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode > 0: busy rises one cycle after the strobe and stays high for mode cycles.
    // mode = 0: busy never rises. mode < 0: busy rises with the strobe and stays high.
    task automatic do_txn(input string tag, input int mode, output logic [IDW-1:0] id,
                          output logic [CMD_W-1:0] bus, output logic [NREQ-1:0] a,
                          output logic e, output int lat);
        logic seen;
        seen = 1'b0;
        id   = '0;
        bus  = '0;
        a    = '0;
        e    = 1'b0;
        lat  = -1;
        for (int i = 0; i < 20; i++) begin
            if (lcd_enable) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_enable_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        id  = gnt_id;
        bus = lcd_bus;
        if (mode < 0) busy = 1'b1;
        seen = 1'b0;
        for (int t = 1; t <= int'(TMO) + 10; t++) begin
            tick();
            if (t == 1) chk({tag, "_enable_one_cycle"}, 32'(lcd_enable), 32'd0);
            if (mode > 0 && t == 1) busy = 1'b1;
            if (mode > 0 && t == mode + 1) busy = 1'b0;
            if (ack != '0) begin
                seen = 1'b1;
                a    = ack;
                e    = err;
                lat  = t;
                break;
            end
        end
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, 1 expected 0");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDW-1:0]   id;
        logic [CMD_W-1:0] bus;
        logic [NREQ-1:0]  a;
        logic             e;
        int               lat;
        int               n_en;
        int               n_ack;

        cmd_tab[0] = 10'h155;
        cmd_tab[1] = 10'h241;
        cmd_tab[2] = 10'h0AA;
        cmd   = {cmd_tab[2], cmd_tab[1], cmd_tab[0]};
        rst_n = 1'b0;
        req   = 3'b111;
        busy  = 1'b1;
        repeat (3) tick();

        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_enable", 32'(lcd_enable), 32'd0);
        chk("rst_bus", 32'(lcd_bus), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);

        // Controller initialising: nothing may be issued.
        rst_n = 1'b1;
        n_en  = 0;
        n_ack = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (lcd_enable) n_en++;
            if (ack != '0) n_ack++;
        end
        chk("t1_no_enable_while_busy", 32'(n_en), 32'd0);
        chk("t1_no_ack_while_busy", 32'(n_ack), 32'd0);

        // All requesting continuously: strict rotation starting at 0.
        busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            do_txn($sformatf("t3_%0d", k), 3, id, bus, a, e, lat);
            chk($sformatf("t3_%0d_gnt_id", k), 32'(id), 32'(k % 3));
            chk($sformatf("t3_%0d_bus", k), 32'(bus), 32'(cmd_tab[k % 3]));
            chk($sformatf("t3_%0d_ack", k), 32'(a), 32'(1 << (k % 3)));
            chk($sformatf("t3_%0d_err", k), 32'(e), 32'd0);
            chk($sformatf("t3_%0d_latency", k), 32'(lat), 32'd6);
        end
        req = 3'b000;

        // Single requester with a 50-cycle busy phase.
        tick();
        req = 3'b010;
        do_txn("t2", 50, id, bus, a, e, lat);
        req = 3'b000;
        chk("t2_gnt_id", 32'(id), 32'd1);
        chk("t2_bus", 32'(bus), 32'h241);
        chk("t2_ack", 32'(a), 32'b010);
        chk("t2_err", 32'(e), 32'd0);
        chk("t2_latency", 32'(lat), 32'd53);
        tick();
        chk("t2_ack_one_cycle", 32'(ack), 32'd0);
        chk("t2_bus_held", 32'(lcd_bus), 32'h241);

        // Busy never rises: timeout in the rise phase.
        req = 3'b001;
        do_txn("t4", 0, id, bus, a, e, lat);
        req = 3'b000;
        chk("t4_gnt_id", 32'(id), 32'd0);
        chk("t4_ack", 32'(a), 32'b001);
        chk("t4_err", 32'(e), 32'd1);
        chk("t4_latency", 32'(lat), 32'(TMO + 3));
        tick();
        req = 3'b100;
        do_txn("t4b", 5, id, bus, a, e, lat);
        req = 3'b000;
        chk("t4b_gnt_id", 32'(id), 32'd2);
        chk("t4b_ack", 32'(a), 32'b100);
        chk("t4b_err", 32'(e), 32'd0);
        chk("t4b_latency", 32'(lat), 32'd8);

        // Busy stuck high: timeout in the fall phase, then no further grants.
        tick();
        req = 3'b010;
        do_txn("t5", -1, id, bus, a, e, lat);
        req = 3'b100;
        chk("t5_gnt_id", 32'(id), 32'd1);
        chk("t5_ack", 32'(a), 32'b010);
        chk("t5_err", 32'(e), 32'd1);
        chk("t5_latency", 32'(lat), 32'(TMO + 3));
        n_en  = 0;
        n_ack = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (lcd_enable) n_en++;
            if (ack != '0) n_ack++;
        end
        chk("t5_blocked_enable", 32'(n_en), 32'd0);
        chk("t5_blocked_ack", 32'(n_ack), 32'd0);

        // Reset while waiting for busy to fall.
        busy = 1'b0;
        n_en = 0;
        for (int i = 0; i < 10; i++) begin
            if (lcd_enable) begin
                n_en = 1;
                break;
            end
            tick();
        end
        chk("t6_enable_seen", 32'(n_en), 32'd1);
        chk("t6_pre_gnt_id", 32'(gnt_id), 32'd2);
        tick();
        busy = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        req   = 3'b111;
        tick();
        busy = 1'b0;
        chk("t6_rst_enable", 32'(lcd_enable), 32'd0);
        chk("t6_rst_ack", 32'(ack), 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_gnt_id", 32'(gnt_id), 32'd0);
        rst_n = 1'b1;
        do_txn("t6", 3, id, bus, a, e, lat);
        req = 3'b000;
        chk("t6_first_gnt_id", 32'(id), 32'd0);
        chk("t6_ack", 32'(a), 32'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
